// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EX and WB.
//   Holds one instruction from EX. For loads and stores it waits for the
//   data-SRAM response of the request EX already issued, then aligns and
//   extends load data. The result goes to WB on the 110-bit MS->WS bus.
//   It also drives forwarding and interlock information back to decode,
//   and squashes its instruction on a WB flush. When it squashes an
//   instruction whose response is still outstanding, it later drops that
//   response.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   ms_allowin         MS can accept an instruction this cycle
//   es_to_ms_valid/bus EX offer and 114-bit EX->MS payload
//   ws_allowin         WB can accept
//   ms_to_ws_valid/bus completed instruction and 110-bit MS->WS payload
//   flush              WB exception or ERET: squash MS
//   data_sram_data_ok  one-cycle response pulse for the outstanding request
//   data_sram_rdata    read data, valid with data_sram_data_ok
//   MEM_dest           destination register for forwarding (0 if none)
//   MEM_dest_data      forwarded result, meaningful while MEM_load_busy=0
//   MEM_load_busy      load held here whose data has not arrived
//   MS_EX              held instruction carries an exception or ERET
module mem_stage #(
   parameter int unsigned ES_TO_MS_BUS_WD = 114,
   parameter int unsigned MS_TO_WS_BUS_WD = 110
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   input  logic                       ws_allowin,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   input  logic                       flush,
   input  logic                       data_sram_data_ok,
   input  logic [31:0]                data_sram_rdata,
   output logic [4:0]                 MEM_dest,
   output logic [31:0]                MEM_dest_data,
   output logic                       MEM_load_busy,
   output logic                       MS_EX
);

   // EX->MS payload, MSB first
   typedef struct packed {
      logic        pc_error;
      logic [31:0] bad_vaddr;
      logic [4:0]  ex_code;
      logic        eret;
      logic        bd;
      logic [2:0]  load_op;
      logic        mem_req;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] alu_result;
      logic [31:0] pc;
   } es_bus_t;

   // MS->WS payload, MSB first
   typedef struct packed {
      logic        pc_error;
      logic [31:0] bad_vaddr;
      logic [4:0]  ex_code;
      logic        eret;
      logic        bd;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] final_result;
      logic [31:0] pc;
   } ws_bus_t;

   typedef enum logic [1:0] {
      S_EMPTY  = 2'd0,
      S_WAIT   = 2'd1,
      S_READY  = 2'd2,
      S_CANCEL = 2'd3
   } state_t;

   localparam logic [2:0] LOAD_NONE = 3'd0;
   localparam logic [2:0] LOAD_LB   = 3'd1;
   localparam logic [2:0] LOAD_LBU  = 3'd2;
   localparam logic [2:0] LOAD_LH   = 3'd3;
   localparam logic [2:0] LOAD_LHU  = 3'd4;

   state_t      state;
   es_bus_t     ms_bus;
   es_bus_t     es_in;
   ws_bus_t     ws_out;
   logic [31:0] data_buf;

   logic        ms_valid;
   logic        ms_ready_go;
   logic        resp_now;
   logic [31:0] raw_data;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] final_result;

   assign es_in = es_to_ms_bus;

   // CANCEL holds no live instruction; it only waits out the orphaned response.
   assign ms_valid    = (state == S_WAIT) || (state == S_READY);
   assign resp_now    = (state == S_WAIT) && data_sram_data_ok;
   assign ms_ready_go = (state == S_READY) || resp_now;

   assign ms_allowin     = (state != S_CANCEL) && (!ms_valid || (ms_ready_go && ws_allowin));
   assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;

   // A response is bypassed in its arrival cycle. A stray data_ok outside
   // WAIT is a protocol error, so it must not disturb the buffered value.
   assign raw_data = resp_now ? data_sram_rdata : data_buf;
   assign sel_byte = raw_data[{ms_bus.alu_result[1:0], 3'b000} +: 8];
   assign sel_half = raw_data[{ms_bus.alu_result[1], 4'b0000} +: 16];

   // Load alignment and extension; the reserved codes behave as LW.
   always_comb begin
      final_result = raw_data;
      case (ms_bus.load_op)
         LOAD_NONE: final_result = ms_bus.alu_result;
         LOAD_LB:   final_result = {{24{sel_byte[7]}}, sel_byte};
         LOAD_LBU:  final_result = {24'd0, sel_byte};
         LOAD_LH:   final_result = {{16{sel_half[15]}}, sel_half};
         LOAD_LHU:  final_result = {16'd0, sel_half};
         default:   final_result = raw_data;
      endcase
   end

   // Outgoing bus: pass-through fields plus the aligned result.
   always_comb begin
      ws_out              = '0;
      ws_out.pc_error     = ms_bus.pc_error;
      ws_out.bad_vaddr    = ms_bus.bad_vaddr;
      ws_out.ex_code      = ms_bus.ex_code;
      ws_out.eret         = ms_bus.eret;
      ws_out.bd           = ms_bus.bd;
      ws_out.gr_we        = ms_bus.gr_we;
      ws_out.dest         = ms_bus.dest;
      ws_out.final_result = final_result;
      ws_out.pc           = ms_bus.pc;
   end

   assign ms_to_ws_bus = ws_out;

   // Forwarding and interlock information for decode
   assign MEM_dest      = (ms_valid && ms_bus.gr_we) ? ms_bus.dest : 5'd0;
   assign MEM_dest_data = final_result;
   assign MEM_load_busy = (state == S_WAIT) && (ms_bus.load_op != LOAD_NONE) && !data_sram_data_ok;
   assign MS_EX         = ms_valid && ((ms_bus.ex_code != 5'd0) || ms_bus.eret);

   // Stage control: flush has priority, then the cancel drain, then the
   // accept (which also covers a same-cycle leave), then leave, then
   // capturing a response that WB cannot take yet.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_EMPTY;
         ms_bus   <= '0;
         data_buf <= '0;
      end else begin
         if (flush) begin
            if (((state == S_WAIT) || (state == S_CANCEL)) && !data_sram_data_ok) begin
               state <= S_CANCEL;
            end else begin
               state <= S_EMPTY;
            end
         end else if (state == S_CANCEL) begin
            if (data_sram_data_ok) begin
               state <= S_EMPTY;
            end
         end else if (es_to_ms_valid && ms_allowin) begin
            ms_bus <= es_in;
            state  <= es_in.mem_req ? S_WAIT : S_READY;
         end else if (ms_to_ws_valid && ws_allowin) begin
            state <= S_EMPTY;
         end else if (resp_now) begin
            data_buf <= data_sram_rdata;
            state    <= S_READY;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change and outputs are checked on
// the falling clock edge, with expected values computed by hand.
module tb_mem_stage;

   logic         clk;
   logic         reset;
   logic         ms_allowin;
   logic         es_to_ms_valid;
   logic [113:0] es_to_ms_bus;
   logic         ws_allowin;
   logic         ms_to_ws_valid;
   logic [109:0] ms_to_ws_bus;
   logic         flush;
   logic         data_sram_data_ok;
   logic [31:0]  data_sram_rdata;
   logic [4:0]   MEM_dest;
   logic [31:0]  MEM_dest_data;
   logic         MEM_load_busy;
   logic         MS_EX;

   int n_total = 0;
   int n_bad   = 0;

   mem_stage dut (
      .clk               (clk),
      .reset             (reset),
      .ms_allowin        (ms_allowin),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .ws_allowin        (ws_allowin),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .flush             (flush),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .MEM_dest          (MEM_dest),
      .MEM_dest_data     (MEM_dest_data),
      .MEM_load_busy     (MEM_load_busy),
      .MS_EX             (MS_EX)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [113:0] mk_es(input logic pe, input logic [31:0] bv, input logic [4:0] ec,
                                          input logic er, input logic bd, input logic [2:0] lo,
                                          input logic mr, input logic gw, input logic [4:0] d,
                                          input logic [31:0] alu, input logic [31:0] pc);
      return {pe, bv, ec, er, bd, lo, mr, gw, d, alu, pc};
   endfunction

   function automatic logic [109:0] mk_ws(input logic pe, input logic [31:0] bv, input logic [4:0] ec,
                                          input logic er, input logic bd, input logic gw,
                                          input logic [4:0] d, input logic [31:0] res, input logic [31:0] pc);
      return {pe, bv, ec, er, bd, gw, d, res, pc};
   endfunction

   // load_op, byte offset, rdata, expected result
   logic [2:0]  v_op  [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd1};
   logic [1:0]  v_a   [7] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2};
   logic [31:0] v_rd  [7] = '{32'h0000_007F, 32'h0000_9A00, 32'h1234_8765, 32'hFFFF_1234,
                              32'hCAFE_BABE, 32'h0123_4567, 32'h0080_0000};
   logic [31:0] v_exp [7] = '{32'h0000_007F, 32'h0000_009A, 32'hFFFF_8765, 32'h0000_1234,
                              32'hCAFE_BABE, 32'h0123_4567, 32'hFFFF_FF80};

   initial begin
      reset             = 1'b1;
      es_to_ms_valid    = 1'b0;
      es_to_ms_bus      = '0;
      ws_allowin        = 1'b1;
      flush             = 1'b0;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = '0;

      // reset state
      @(negedge clk); #1;
      chk("rst_allowin", 128'(ms_allowin), 128'd1);
      chk("rst_valid", 128'(ms_to_ws_valid), 128'd0);
      chk("rst_bus", 128'(ms_to_ws_bus), 128'd0);
      chk("rst_dest", 128'(MEM_dest), 128'd0);
      chk("rst_busy", 128'(MEM_load_busy), 128'd0);
      chk("rst_msex", 128'(MS_EX), 128'd0);
      @(negedge clk);
      reset = 1'b0;

      // plain ALU op
      @(negedge clk);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_es(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'hBFC0_0000);
      #1 chk("alu_allowin_empty", 128'(ms_allowin), 128'd1);
      @(negedge clk);
      es_to_ms_valid = 1'b0;
      #1;
      chk("alu_valid", 128'(ms_to_ws_valid), 128'd1);
      chk("alu_bus", 128'(ms_to_ws_bus),
          128'(mk_ws(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'hBFC0_0000)));
      chk("alu_allowin", 128'(ms_allowin), 128'd1);
      chk("alu_fwd_dest", 128'(MEM_dest), 128'd5);
      chk("alu_fwd_data", 128'(MEM_dest_data), 128'h1234);
      @(negedge clk); #1;
      chk("alu_gone", 128'(ms_to_ws_valid), 128'd0);

      // LB at offset 3, response two cycles after accept
      @(negedge clk);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_es(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 5'd7, 32'h0000_1003, 32'hBFC0_0010);
      @(negedge clk);
      es_to_ms_valid = 1'b0;
      #1;
      chk("lb_busy", 128'(MEM_load_busy), 128'd1);
      chk("lb_wait_valid", 128'(ms_to_ws_valid), 128'd0);
      chk("lb_wait_allowin", 128'(ms_allowin), 128'd0);
      chk("lb_wait_dest", 128'(MEM_dest), 128'd7);
      @(negedge clk);
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h80FF_FF01;
      #1;
      chk("lb_valid", 128'(ms_to_ws_valid), 128'd1);
      chk("lb_result", 128'(ms_to_ws_bus[63:32]), 128'hFFFF_FF80);
      chk("lb_allowin", 128'(ms_allowin), 128'd1);
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      #1;
      chk("lb_gone", 128'(ms_to_ws_valid), 128'd0);
      chk("lb_busy_clear", 128'(MEM_load_busy), 128'd0);

      // LHU at offset 2 while WB stalls: result comes from the buffer
      @(negedge clk);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_es(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 5'd9, 32'h0000_2002, 32'hBFC0_0020);
      @(negedge clk);
      es_to_ms_valid    = 1'b0;
      ws_allowin        = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h8001_0000;
      #1 chk("lhu_allowin_stall", 128'(ms_allowin), 128'd0);
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'hDEAD_BEEF;
      #1;
      chk("lhu_hold_valid", 128'(ms_to_ws_valid), 128'd1);
      chk("lhu_hold_result", 128'(ms_to_ws_bus[63:32]), 128'h0000_8001);
      chk("lhu_hold_busy", 128'(MEM_load_busy), 128'd0);
      @(negedge clk);
      ws_allowin = 1'b1;
      #1;
      chk("lhu_result", 128'(ms_to_ws_bus[63:32]), 128'h0000_8001);
      chk("lhu_allowin", 128'(ms_allowin), 128'd1);
      @(negedge clk); #1;
      chk("lhu_gone", 128'(ms_to_ws_valid), 128'd0);

      // load-op table, response one cycle after accept
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         es_to_ms_valid = 1'b1;
         es_to_ms_bus   = mk_es(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, v_op[i], 1'b1, 1'b1, 5'd3,
                                32'h0000_1000 | 32'(v_a[i]), 32'hBFC0_0100);
         @(negedge clk);
         es_to_ms_valid    = 1'b0;
         data_sram_data_ok = 1'b1;
         data_sram_rdata   = v_rd[i];
         #1;
         chk($sformatf("ld%0d_valid", i), 128'(ms_to_ws_valid), 128'd1);
         chk($sformatf("ld%0d_result", i), 128'(ms_to_ws_bus[63:32]), 128'(v_exp[i]));
         @(negedge clk);
         data_sram_data_ok = 1'b0;
      end

      // flush during WAIT, orphaned response three cycles later
      @(negedge clk);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_es(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 5'd4, 32'h0000_3000, 32'hBFC0_0200);
      @(negedge clk);
      flush = 1'b1;
      #1 chk("fl_valid", 128'(ms_to_ws_valid), 128'd0);
      @(negedge clk);
      flush          = 1'b0;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_es(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd6, 32'h0000_0077, 32'hBFC0_0204);
      #1;
      chk("fl_cancel_allowin1", 128'(ms_allowin), 128'd0);
      chk("fl_cancel_valid", 128'(ms_to_ws_valid), 128'd0);
      @(negedge clk); #1;
      chk("fl_cancel_allowin2", 128'(ms_allowin), 128'd0);
      @(negedge clk);
      es_to_ms_valid    = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h1111_2222;
      #1;
      chk("fl_drop_allowin", 128'(ms_allowin), 128'd0);
      chk("fl_drop_valid", 128'(ms_to_ws_valid), 128'd0);
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      #1;
      chk("fl_after_allowin", 128'(ms_allowin), 128'd1);
      chk("fl_after_valid", 128'(ms_to_ws_valid), 128'd0);

      // exception instruction passes through bit-exact, then back-to-back ALU op
      @(negedge clk);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_es(1'b1, 32'h1234_5677, 5'h04, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 5'd3,
                             32'h0000_0055, 32'h8000_0100);
      @(negedge clk);
      es_to_ms_bus = mk_es(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 5'd8, 32'hABCD_0000, 32'h8000_0104);
      #1;
      chk("exc_valid", 128'(ms_to_ws_valid), 128'd1);
      chk("exc_msex", 128'(MS_EX), 128'd1);
      chk("exc_bus", 128'(ms_to_ws_bus),
          128'(mk_ws(1'b1, 32'h1234_5677, 5'h04, 1'b0, 1'b1, 1'b0, 5'd3, 32'h0000_0055, 32'h8000_0100)));
      chk("exc_dest", 128'(MEM_dest), 128'd0);
      chk("b2b_allowin", 128'(ms_allowin), 128'd1);
      @(negedge clk);
      es_to_ms_valid = 1'b0;
      #1;
      chk("b2b_valid", 128'(ms_to_ws_valid), 128'd1);
      chk("b2b_result", 128'(ms_to_ws_bus[63:32]), 128'hABCD_0000);
      chk("b2b_msex", 128'(MS_EX), 128'd0);

      // reset mid-WAIT, stale response afterwards
      @(negedge clk);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_es(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 5'd2, 32'h0000_4000, 32'hBFC0_0300);
      @(negedge clk);
      es_to_ms_valid = 1'b0;
      #1 chk("rw_busy", 128'(MEM_load_busy), 128'd1);
      #2 reset = 1'b1;
      #1;
      chk("rw_allowin", 128'(ms_allowin), 128'd1);
      chk("rw_busy_clear", 128'(MEM_load_busy), 128'd0);
      chk("rw_bus", 128'(ms_to_ws_bus), 128'd0);
      chk("rw_dest", 128'(MEM_dest), 128'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h5555_AAAA;
      #1;
      chk("rw_stale_valid", 128'(ms_to_ws_valid), 128'd0);
      chk("rw_stale_allowin", 128'(ms_allowin), 128'd1);
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      #1;
      chk("rw_stale_after", 128'(ms_to_ws_valid), 128'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
